scan_chain_slot: RTL and testbench
==================================

// Module: scan_chain_slot
// PURPOSE
//  One slot of the design scan chain, directly downstream of scan_controller. It receives
//  the controller's scan_clk/data/select/latch, presents latched inputs to one user design,
//  and captures that design's outputs for shifting back. Slots are cascaded: each slot's
//  scan_data_out feeds the next slot's scan_data_in. Control signals pass straight through.
//  Runs on the controller's system clock; scan_clk is sampled as data and edge-detected.
// PARAMETERS
//  WIDTH       8  design I/O bits per slot (matches controller NUM_IOS)
//  LATCH_INIT  0  value driven on module_data_in after reset
// PORTS
//  clk                    in   1      system clock, same clock as scan_controller
//  reset                  in   1      asynchronous, active-high
//  scan_clk_in            in   1      scan clock level from upstream
//  scan_data_in           in   1      serial data from upstream
//  scan_select_in         in   1      high = capture design outputs into shift reg
//  scan_latch_enable_in   in   1      high = copy shift reg to design inputs
//  scan_clk_out           out  1      = scan_clk_in (combinational)
//  scan_select_out        out  1      = scan_select_in (combinational)
//  scan_latch_enable_out  out  1      = scan_latch_enable_in (combinational)
//  scan_data_out          out  1      = shift_reg[WIDTH-1]
//  module_data_in         out  WIDTH  latched inputs to the user design
//  module_data_out        in   WIDTH  outputs from the user design
//  frame_error            out  1      sticky: latch seen with bit count not multiple of WIDTH
// BEHAVIOUR
//  Reset (async): shift_reg=0, module_data_in=LATCH_INIT, scan_clk_d=0, bit_cnt=0, frame_error=0.
//  Edge detect: scan_clk_d <= scan_clk_in each clk; rise = scan_clk_in & ~scan_clk_d.
//   A level held high for many cycles is one rise; first cycle after reset cannot rise if in=0.
//  Per clk, priority order (one action on shift_reg):
//   1 scan_select_in=1 : shift_reg <= module_data_out; bit_cnt <= 0; rise ignored.
//   2 rise             : shift_reg <= {shift_reg[WIDTH-2:0], scan_data_in};
//                        bit_cnt <= (bit_cnt==WIDTH-1) ? 0 : bit_cnt+1.
//   3 otherwise hold.
//  Latch: scan_latch_enable_in=1 -> module_data_in <= shift_reg (pre-update value); same clk:
//   if bit_cnt!=0 set frame_error; bit_cnt <= 0 unless select also high (also 0). Level-sensitive
//   per clk: a multi-cycle latch pulse recopies each cycle (harmless, idempotent if no rise).
//  Latch + select same clk: both occur; latch uses old shift_reg.
//  Latch + rise same clk: latch uses old shift_reg; shift still occurs.
//  Bit order: MSB first; after WIDTH rises first-sent bit sits at shift_reg[WIDTH-1].
//   Capture sends module_data_out[WIDTH-1] first on scan_data_out.
//  Cascade: all slots share clk; slot k+1 samples slot k's pre-shift MSB -> true shift chain.
//  Latency: module_data_in valid 1 clk after latch; scan_data_out valid 1 clk after select/rise.
//  frame_error cleared only by reset. module_data_in never changes except on latch or reset.
//  Reset mid-frame: all state cleared immediately; controller restart re-frames cleanly.
//  bit_cnt width = $clog2(WIDTH); WIDTH>=2 required.
// STRUCTURE
//  Shared header scan_defs.vh: `SCAN_IO_WIDTH (8), `SCAN_NUM_DESIGNS (8) used by controller & slot.
//  Sub-module scan_edge_detect (clk, reset, level_in, rise_out): the scan_clk_d register + rise.
//  Top-level chain generate-loop of scan_chain_slot instances lives with the controller wrapper.
// TESTING
//  1 Reset: assert reset async mid-clock -> module_data_in=LATCH_INIT, scan_data_out=0, frame_error=0.
//  2 Load: shift 8'hA5 MSB first (8 rises), latch 1 clk -> module_data_in=8'hA5, frame_error=0.
//  3 Capture: module_data_out=8'h3C, select 1 clk, 8 rises -> scan_data_out seq 0,0,1,1,1,1,0,0.
//  4 Chain of 8 slots + scan_controller, active_select=2, inputs=8'h5A -> slot 2 module_data_in=8'h5A,
//    others 0; slot 2 module_data_out=8'hC3 -> controller outputs=8'hC3 after next refresh.
//  5 Framing: 5 rises then latch -> frame_error=1, stays 1 after further good frames until reset.
//  6 Collisions: select and rise same clk -> capture wins, bit_cnt=0; latch+select same clk ->
//    module_data_in = old shift_reg, shift_reg = module_data_out; scan_clk held high 10 clks -> 1 shift.

Source files
------------

// File: rtl/scan_chain_slot_pkg.sv
// rtl/scan_chain_slot_pkg.sv - shared scan chain sizing and shift-register action encoding
package scan_chain_slot_pkg;

  localparam int SCAN_IO_WIDTH    = 8;
  localparam int SCAN_NUM_DESIGNS = 8;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_CAPTURE = 2'd1,
    SR_SHIFT   = 2'd2
  } sr_op_e;

  // Capture outranks a scan clock rise arriving in the same cycle.
  function automatic sr_op_e sr_op_sel(input logic select, input logic rise);
    if (select)    return SR_CAPTURE;
    else if (rise) return SR_SHIFT;
    else           return SR_HOLD;
  endfunction

endpackage

// File: rtl/scan_edge_detect.sv
// rtl/scan_edge_detect.sv - registers a sampled scan clock level and flags its rising edge
module scan_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic rise_out
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level_in;
  end

  assign rise_out = level_in & ~level_q;

endmodule

// File: rtl/scan_chain_slot.sv
// rtl/scan_chain_slot.sv - one scan chain slot: shifts, captures design outputs, latches design inputs
module scan_chain_slot
  import scan_chain_slot_pkg::*;
#(
  parameter int               WIDTH      = SCAN_IO_WIDTH,
  parameter logic [WIDTH-1:0] LATCH_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_clk_in,
  input  logic             scan_data_in,
  input  logic             scan_select_in,
  input  logic             scan_latch_enable_in,
  output logic             scan_clk_out,
  output logic             scan_select_out,
  output logic             scan_latch_enable_out,
  output logic             scan_data_out,
  output logic [WIDTH-1:0] module_data_in,
  input  logic [WIDTH-1:0] module_data_out,
  output logic             frame_error
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic             rise;
  sr_op_e           op;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ferr_q, ferr_d;

  scan_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (scan_clk_in),
    .rise_out (rise)
  );

  assign op = sr_op_sel(scan_select_in, rise);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    ferr_d  = ferr_q;
    unique case (op)
      SR_CAPTURE: begin
        shift_d = module_data_out;
        cnt_d   = '0;
      end
      SR_SHIFT: begin
        shift_d = {shift_q[WIDTH-2:0], scan_data_in};
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      end
      default: ;
    endcase
    // Latch copies the pre-update shift register so a coincident shift or capture is not seen.
    if (scan_latch_enable_in) begin
      latch_d = shift_q;
      cnt_d   = '0;
      if (cnt_q != '0) ferr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      latch_q <= LATCH_INIT;
      cnt_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      ferr_q  <= ferr_d;
    end
  end

  assign scan_clk_out          = scan_clk_in;
  assign scan_select_out       = scan_select_in;
  assign scan_latch_enable_out = scan_latch_enable_in;
  assign scan_data_out         = shift_q[WIDTH-1];
  assign module_data_in        = latch_q;
  assign frame_error           = ferr_q;

endmodule

// File: tb/tb_scan_chain_slot.sv
// tb/tb_scan_chain_slot.sv - randomized scoreboard bench for scan_chain_slot
module tb_scan_chain_slot;

  localparam int             W    = 8;
  localparam logic [W-1:0]   INIT = 8'h96;

  logic         clk = 1'b0;
  logic         reset;
  logic         scan_clk_in, scan_data_in, scan_select_in, scan_latch_enable_in;
  logic         scan_clk_out, scan_select_out, scan_latch_enable_out, scan_data_out;
  logic [W-1:0] module_data_in, module_data_out;
  logic         frame_error;

  int n_checks = 0;
  int n_pass   = 0;

  // {scan_data_out, module_data_in, frame_error, clk_out, select_out, latch_out}
  logic [W+4:0] exp_q[$];

  // Reference model: the shift register as an integer, the bit count since the last frame start.
  int unsigned m_sr, m_mdi, m_cnt;
  bit          m_ferr, m_prev_clk;

  scan_chain_slot #(.WIDTH(W), .LATCH_INIT(INIT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .scan_clk_in           (scan_clk_in),
    .scan_data_in          (scan_data_in),
    .scan_select_in        (scan_select_in),
    .scan_latch_enable_in  (scan_latch_enable_in),
    .scan_clk_out          (scan_clk_out),
    .scan_select_out       (scan_select_out),
    .scan_latch_enable_out (scan_latch_enable_out),
    .scan_data_out         (scan_data_out),
    .module_data_in        (module_data_in),
    .module_data_out       (module_data_out),
    .frame_error           (frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_sr       = 0;
    m_mdi      = INIT;
    m_cnt      = 0;
    m_ferr     = 0;
    m_prev_clk = 0;
  endfunction

  // Drive one clock of stimulus on the falling edge and push what the slot must show after the next rise.
  task automatic cyc(input bit sc, input bit sd, input bit sel, input bit lat, input logic [W-1:0] mdo);
    bit rise;
    @(negedge clk);
    scan_clk_in          = sc;
    scan_data_in         = sd;
    scan_select_in       = sel;
    scan_latch_enable_in = lat;
    module_data_out      = mdo;
    rise       = sc && !m_prev_clk;
    m_prev_clk = sc;
    if (lat) begin
      m_mdi = m_sr;
      if (m_cnt % W != 0) m_ferr = 1;
    end
    if (sel) begin
      m_sr  = mdo;
      m_cnt = 0;
    end else if (rise) begin
      m_sr  = ((m_sr * 2) + sd) % (1 << W);
      m_cnt = m_cnt + 1;
    end
    if (lat) m_cnt = 0;
    exp_q.push_back({(m_sr >> (W - 1)) % 2 == 1, m_mdi[W-1:0], m_ferr, sc, sel, lat});
  endtask

  task automatic send_bit(input bit b);
    cyc(1, b, 0, 0, 8'h00);
    cyc(0, b, 0, 0, 8'h00);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset                = 1'b1;
    scan_clk_in          = 1'b0;
    scan_select_in       = 1'b0;
    scan_latch_enable_in = 1'b0;
    #1;
    check("reset_mdi", module_data_in, INIT);
    check("reset_sdo", scan_data_out, 0);
    check("reset_ferr", frame_error, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      logic [W+4:0] e;
      e = exp_q.pop_front();
      check("scoreboard",
            {scan_data_out, module_data_in, frame_error, scan_clk_out, scan_select_out, scan_latch_enable_out},
            e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5 = 8'hA5;
    logic [7:0] seq = 8'b0011_1100;
    reset                = 1'b1;
    scan_clk_in          = 1'b0;
    scan_data_in         = 1'b0;
    scan_select_in       = 1'b0;
    scan_latch_enable_in = 1'b0;
    module_data_out      = '0;
    model_reset();
    #12;
    check("init_mdi", module_data_in, INIT);
    check("init_ferr", frame_error, 0);
    @(negedge clk);
    reset = 1'b0;

    // Load A5 MSB first and latch it.
    for (int i = W - 1; i >= 0; i--) send_bit(a5[i]);
    cyc(0, 0, 0, 1, 8'h00);
    settle();
    check("load_mdi", module_data_in, 8'hA5);
    check("load_ferr", frame_error, 0);

    // Capture 3C and watch it come out MSB first.
    cyc(0, 0, 1, 0, 8'h3C);
    settle();
    check("cap_bit0", scan_data_out, seq[7]);
    for (int i = 1; i < W; i++) begin
      cyc(1, 0, 0, 0, 8'h3C);
      settle();
      check("cap_seq", scan_data_out, seq[7-i]);
      cyc(0, 0, 0, 0, 8'h3C);
    end
    check("cap_mdi_hold", module_data_in, 8'hA5);

    // Short frame then a good frame: the error must stick.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cyc(0, 0, 0, 1, 8'h00);
    settle();
    check("short_frame_ferr", frame_error, 1);
    for (int i = 0; i < W; i++) send_bit(1'b0);
    cyc(0, 0, 0, 1, 8'h00);
    settle();
    check("sticky_ferr", frame_error, 1);
    async_reset();

    // Collisions: select with rise, latch with select, long scan clock high.
    send_bit(1'b1);
    cyc(1, 1, 1, 0, 8'h81);
    cyc(0, 0, 0, 0, 8'h81);
    cyc(0, 0, 1, 1, 8'h42);
    settle();
    check("latch_sel_mdi", module_data_in, 8'h81);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < W - 1; i++) send_bit(1'b0);
    cyc(0, 0, 0, 1, 8'h00);
    settle();
    check("long_high_one_shift", module_data_in, 8'h80);
    check("long_high_ferr", frame_error, 0);

    // Random traffic, with an async reset dropped into the middle.
    for (int n = 0; n < 2000; n++) begin
      bit sc, sel, lat;
      sc  = ($urandom_range(0, 2) == 0) ? ~scan_clk_in : scan_clk_in;
      sel = ($urandom_range(0, 24) == 0);
      lat = ($urandom_range(0, 19) == 0);
      cyc(sc, 1'($urandom), sel, lat, 8'($urandom));
      if (n == 1000) async_reset();
    end

    cyc(0, 0, 0, 0, 8'h00);
    settle();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
